ram_stream_writer: RTL

- Loads a single-port coefficient/table RAM from a valid/ready word stream, writing addresses 0..WORD_NUM-1 in order.
- It is the write-side counterpart of the single-port ROM readers, so filter tables can be reloaded at runtime instead of fixed at synthesis.
- Sits between a host/config stream and the RAM write port; the filter datapath reads the RAM once done pulses.

---
 rtl/ram_stream_writer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram_stream_writer.sv
// ram_stream_writer: loads RAM words 0..WORD_NUM-1 from a valid/ready stream; optional readback check via RAM_STREAM_WRITER_READBACK_CHECK_EN
module ram_stream_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADR_WIDTH  = 8,
  parameter int WORD_NUM   = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADR_WIDTH-1:0]  mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADR_WIDTH:0]    word_cnt
);
  localparam logic [ADR_WIDTH:0] LAST = (ADR_WIDTH+1)'(WORD_NUM - 1);
  localparam logic [ADR_WIDTH:0] ONE  = (ADR_WIDTH+1)'(1);
`ifdef RAM_STREAM_WRITER_READBACK_CHECK_EN
  typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;
`endif
  state_e                state_q, state_d;
  logic                  s_ready_q, mem_we_q, mem_we_d, busy_q, done_q, err_q, err_d, hs, go;
  logic [ADR_WIDTH-1:0]  mem_adr_q, mem_adr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADR_WIDTH:0]    cnt_q, cnt_d;
  assign hs = s_valid & s_ready_q;
  assign go = state_q == IDLE && start && !abort;
`ifdef RAM_STREAM_WRITER_READBACK_CHECK_EN
  localparam int CW = DATA_WIDTH + ADR_WIDTH;
  localparam logic [ADR_WIDTH:0] NUM = (ADR_WIDTH+1)'(WORD_NUM);
  logic [CW-1:0]         wsum_q, wsum_d, rsum_q, rsum_d;
  logic [ADR_WIDTH:0]    rd_cnt_q, rd_cnt_d, rcv_q, rcv_d;
  logic [RD_LATENCY-1:0] dl_q, dl_d;
  logic                  adr_v_q, adr_v_d, rd_hit, chk_last, chk_bad;
  assign rd_hit   = dl_q[RD_LATENCY-1];
  assign chk_last = rd_hit && rcv_q == LAST;
  assign chk_bad  = (rsum_q + CW'(mem_q)) != wsum_q;
  // write/read checksums, read address sequencer and the read-valid delay line qualifying mem_q
  always_comb begin
    adr_v_d  = state_q == CHECK && rd_cnt_q != NUM;
    rd_cnt_d = go ? '0 : rd_cnt_q + (ADR_WIDTH+1)'(adr_v_d);
    wsum_d   = go ? '0 : hs ? wsum_q + CW'(s_data) : wsum_q;
    rsum_d   = go ? '0 : rd_hit ? rsum_q + CW'(mem_q) : rsum_q;
    rcv_d    = go ? '0 : rcv_q + (ADR_WIDTH+1)'(rd_hit);
    dl_d     = go ? '0 : (dl_q << 1) | RD_LATENCY'(adr_v_q);
  end
  // readback check registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wsum_q   <= '0;
      rsum_q   <= '0;
      rd_cnt_q <= '0;
      rcv_q    <= '0;
      dl_q     <= '0;
      adr_v_q  <= 1'b0;
    end else begin
      wsum_q   <= wsum_d;
      rsum_q   <= rsum_d;
      rd_cnt_q <= rd_cnt_d;
      rcv_q    <= rcv_d;
      dl_q     <= dl_d;
      adr_v_q  <= adr_v_d;
    end
`else
  logic unused_mem_q;
  localparam int unused_rd_latency = RD_LATENCY;
  assign unused_mem_q = ^mem_q;
`endif
  // next state, write port and error flag; a handshake always lands as a write one cycle later
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = hs;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    if (hs) begin
      mem_adr_d   = cnt_q[ADR_WIDTH-1:0];
      mem_wdata_d = s_data;
      cnt_d       = cnt_q + ONE;
    end
`ifdef RAM_STREAM_WRITER_READBACK_CHECK_EN
    if (adr_v_d) mem_adr_d = rd_cnt_q[ADR_WIDTH-1:0];
`endif
    case (state_q)
      IDLE: if (go) begin
        state_d = WRITE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      WRITE: if (abort) begin
        state_d = IDLE;
        err_d   = 1'b1;
`ifdef RAM_STREAM_WRITER_READBACK_CHECK_EN
      end else if (hs && cnt_q == LAST) state_d = CHECK;
      CHECK: if (abort) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (chk_last) begin
        state_d = DONE;
        err_d   = chk_bad;
      end
`else
      end else if (hs && cnt_q == LAST) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= state_d == WRITE;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  assign s_ready   = s_ready_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign word_cnt  = cnt_q;
endmodule
